// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - funct codes and FSM state encoding for the ALU execute block
package alu_pkg;

  localparam int FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 6'b001001;
  localparam logic [FUNCT_W-1:0] FUNCT_SUBU = 6'b001010;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR  = 6'b010011;
  localparam logic [FUNCT_W-1:0] FUNCT_SLTU = 6'b101010;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL  = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic funct_is_legal(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_ADDU) || (f == FUNCT_SUBU) || (f == FUNCT_NOR) ||
           (f == FUNCT_SLTU) || (f == FUNCT_SRL);
  endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational single-cycle datapath (Addu/Subu/Nor/Sltu/illegal)
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  src1,
  input  logic [DATA_W-1:0]  src2,
  output logic [DATA_W-1:0]  result,
  output logic               illegal
);

  always_comb begin
    result  = '0;
    illegal = !funct_is_legal(funct);
    // Srl is legal but produced by the shifter in the top, so it yields 0 here
    case (funct)
      FUNCT_ADDU: result = src1 + src2;
      FUNCT_SUBU: result = src1 - src2;
      FUNCT_NOR:  result = ~(src1 | src2);
      FUNCT_SLTU: result = DATA_W'(src1 < src2);
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - ALU execute stage: valid/ready handshake, one-cycle ops and
// a bit-serial logical right shifter driven by a three-state FSM
module alu_exec
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  src1,
  input  logic [DATA_W-1:0]  src2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               zero,
  output logic               illegal,
  output logic               busy
);

  state_t state, next_state;

  logic [DATA_W-1:0]  shift_reg;
  logic [SHAMT_W-1:0] cnt;
  logic [DATA_W-1:0]  shifted;
  logic [DATA_W-1:0]  core_result;
  logic               core_illegal;
  logic [DATA_W-1:0]  single_result;
  logic               accept;
  logic               load_single;
  logic               load_shift;
  logic               shift_step;
  logic               shift_last;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .funct   (funct),
    .src1    (src1),
    .src2    (src2),
    .result  (core_result),
    .illegal (core_illegal)
  );

  assign shifted       = shift_reg >> 1;
  assign single_result = (funct == FUNCT_SRL) ? src1 : core_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    shift_step  = 1'b0;
    shift_last  = 1'b0;
    load_single = 1'b0;
    load_shift  = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_SHIFT: begin
        busy       = 1'b1;
        shift_step = 1'b1;
        if (cnt <= SHAMT_W'(1)) begin
          shift_last = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    accept = in_valid && in_ready;
    // An accept in DONE overrides the drain-to-IDLE so single-cycle ops stream
    if (accept) begin
      if (funct == FUNCT_SRL && shamt != '0) begin
        load_shift = 1'b1;
        next_state = ST_SHIFT;
      end else begin
        load_single = 1'b1;
        next_state  = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (load_shift) begin
        shift_reg <= src1;
        cnt       <= shamt;
      end else if (shift_step) begin
        shift_reg <= shifted;
        cnt       <= cnt - SHAMT_W'(1);
      end
      if (load_single) begin
        result  <= single_result;
        zero    <= (single_result == '0);
        illegal <= core_illegal;
      end else if (shift_last) begin
        result  <= shifted;
        zero    <= (shifted == '0);
        illegal <= 1'b0;
      end
    end
  end

endmodule
